// File: rtl/id_ex_stage.sv
// ID/EX pipeline register of the 5-stage RISC-V core.
// Registers the decoded control bundle and operands for execute, detects
// load-use hazards, inserts bubbles, drives front-end stall/flush controls
// and keeps saturating stall/flush performance counters.
module id_ex_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ext_stall,
  input  logic             pc_src_e,
  input  logic             cnt_clr,
  input  logic             id_valid,
  input  logic             id_reg_w,
  input  logic             id_mem_w,
  input  logic             id_branch,
  input  logic             id_jump,
  input  logic             id_alu_src,
  input  logic [1:0]       id_result_src,
  input  logic [2:0]       id_alu_ctrl,
  input  logic [XLEN-1:0]  id_rd1,
  input  logic [XLEN-1:0]  id_rd2,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [XLEN-1:0]  id_pc_plus4,
  input  logic [XLEN-1:0]  id_imm_ext,
  output logic             ex_valid,
  output logic             ex_reg_w,
  output logic             ex_mem_w,
  output logic             ex_branch,
  output logic             ex_jump,
  output logic             ex_alu_src,
  output logic [1:0]       ex_result_src,
  output logic [2:0]       ex_alu_ctrl,
  output logic [XLEN-1:0]  ex_rd1,
  output logic [XLEN-1:0]  ex_rd2,
  output logic [4:0]       ex_rs1,
  output logic [4:0]       ex_rs2,
  output logic [4:0]       ex_rd,
  output logic [XLEN-1:0]  ex_pc,
  output logic [XLEN-1:0]  ex_pc_plus4,
  output logic [XLEN-1:0]  ex_imm_ext,
  output logic             stall_f,
  output logic             stall_d,
  output logic             flush_d,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [1:0]       RES_MEM = 2'b01;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic lu;
  logic bubble;

  // A load in EX whose destination feeds the instruction in ID. The rs2
  // compare is done for every instruction; a spurious stall is harmless.
  assign lu = ex_valid & (ex_result_src == RES_MEM) & (ex_rd != 5'd0) & id_valid &
              ((ex_rd == id_rs1) | (ex_rd == id_rs2));

  // Priority: ext_stall freezes everything, a redirect beats a load-use stall.
  assign stall_f = ext_stall | (~pc_src_e & lu);
  assign stall_d = stall_f;
  assign flush_d = ~ext_stall & pc_src_e;
  assign bubble  = ~ext_stall & (pc_src_e | lu);

  // ID/EX register: hold on ext_stall, load a bubble on redirect or load-use,
  // otherwise capture the decode stage.
  // NOTE: every register here is a plain flop (no memory array), so all of it
  // is cleared by the asynchronous reset, not only the valid bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      ex_valid      <= 1'b0;
      ex_reg_w      <= 1'b0;
      ex_mem_w      <= 1'b0;
      ex_branch     <= 1'b0;
      ex_jump       <= 1'b0;
      ex_alu_src    <= 1'b0;
      ex_result_src <= '0;
      ex_alu_ctrl   <= '0;
      ex_rd1        <= '0;
      ex_rd2        <= '0;
      ex_rs1        <= '0;
      ex_rs2        <= '0;
      ex_rd         <= '0;
      ex_pc         <= '0;
      ex_pc_plus4   <= '0;
      ex_imm_ext    <= '0;
    end else if (!ext_stall) begin
      if (bubble) begin
        ex_valid      <= 1'b0;
        ex_reg_w      <= 1'b0;
        ex_mem_w      <= 1'b0;
        ex_branch     <= 1'b0;
        ex_jump       <= 1'b0;
        ex_alu_src    <= 1'b0;
        ex_result_src <= '0;
        ex_alu_ctrl   <= '0;
        ex_rd1        <= '0;
        ex_rd2        <= '0;
        ex_rs1        <= '0;
        ex_rs2        <= '0;
        ex_rd         <= '0;
        ex_pc         <= '0;
        ex_pc_plus4   <= '0;
        ex_imm_ext    <= '0;
      end else begin
        ex_valid      <= id_valid;
        ex_reg_w      <= id_reg_w;
        ex_mem_w      <= id_mem_w;
        ex_branch     <= id_branch;
        ex_jump       <= id_jump;
        ex_alu_src    <= id_alu_src;
        ex_result_src <= id_result_src;
        ex_alu_ctrl   <= id_alu_ctrl;
        ex_rd1        <= id_rd1;
        ex_rd2        <= id_rd2;
        ex_rs1        <= id_rs1;
        ex_rs2        <= id_rs2;
        ex_rd         <= id_rd;
        ex_pc         <= id_pc;
        ex_pc_plus4   <= id_pc_plus4;
        ex_imm_ext    <= id_imm_ext;
      end
    end
  end

  // Saturating performance counters; a clear wins over an increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (cnt_clr) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_f && stall_cnt != CNT_MAX) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_d && flush_cnt != CNT_MAX) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios followed by random
// traffic, compared against a priority-rule reference model.
module tb_id_ex_stage;

  localparam int XLEN  = 32;
  localparam int CNT_W = 4;
  localparam int SAT   = (1 << CNT_W) - 1;

  typedef struct packed {
    logic            valid;
    logic            reg_w;
    logic            mem_w;
    logic            branch;
    logic            jump;
    logic            alu_src;
    logic [1:0]      result_src;
    logic [2:0]      alu_ctrl;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] imm_ext;
  } bundle_t;

  logic clk = 1'b0;
  logic rst_n, ext_stall, pc_src_e, cnt_clr;
  bundle_t id, ex_obs, m_ex;
  logic stall_f, stall_d, flush_d;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  int m_scnt, m_fcnt;
  int tests = 0;
  int fails = 0;

  logic             ex_valid, ex_reg_w, ex_mem_w, ex_branch, ex_jump, ex_alu_src;
  logic [1:0]       ex_result_src;
  logic [2:0]       ex_alu_ctrl;
  logic [XLEN-1:0]  ex_rd1, ex_rd2, ex_pc, ex_pc_plus4, ex_imm_ext;
  logic [4:0]       ex_rs1, ex_rs2, ex_rd;

  assign ex_obs = {ex_valid, ex_reg_w, ex_mem_w, ex_branch, ex_jump, ex_alu_src,
                   ex_result_src, ex_alu_ctrl, ex_rd1, ex_rd2, ex_rs1, ex_rs2,
                   ex_rd, ex_pc, ex_pc_plus4, ex_imm_ext};

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .ext_stall(ext_stall), .pc_src_e(pc_src_e),
    .cnt_clr(cnt_clr), .id_valid(id.valid), .id_reg_w(id.reg_w),
    .id_mem_w(id.mem_w), .id_branch(id.branch), .id_jump(id.jump),
    .id_alu_src(id.alu_src), .id_result_src(id.result_src),
    .id_alu_ctrl(id.alu_ctrl), .id_rd1(id.rd1), .id_rd2(id.rd2),
    .id_rs1(id.rs1), .id_rs2(id.rs2), .id_rd(id.rd), .id_pc(id.pc),
    .id_pc_plus4(id.pc_plus4), .id_imm_ext(id.imm_ext),
    .ex_valid(ex_valid), .ex_reg_w(ex_reg_w), .ex_mem_w(ex_mem_w),
    .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_alu_src(ex_alu_src),
    .ex_result_src(ex_result_src), .ex_alu_ctrl(ex_alu_ctrl),
    .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_rd(ex_rd), .ex_pc(ex_pc), .ex_pc_plus4(ex_pc_plus4),
    .ex_imm_ext(ex_imm_ext), .stall_f(stall_f), .stall_d(stall_d),
    .flush_d(flush_d), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Build a decoded instruction; data fields get random contents.
  function automatic bundle_t mk_instr(input logic reg_w, input logic [1:0] res,
                                       input logic alu_src, input int rs1, input int rs2,
                                       input int rd, input int imm);
    bundle_t b;
    b            = '0;
    b.valid      = 1'b1;
    b.reg_w      = reg_w;
    b.alu_src    = alu_src;
    b.result_src = res;
    b.rs1        = 5'(rs1);
    b.rs2        = 5'(rs2);
    b.rd         = 5'(rd);
    b.imm_ext    = XLEN'(imm);
    b.rd1        = $urandom;
    b.rd2        = $urandom;
    b.pc         = $urandom & 32'hffff_fffc;
    b.pc_plus4   = b.pc + 32'd4;
    return b;
  endfunction

  // Random instruction with small register indices so hazards are frequent.
  function automatic bundle_t rand_instr();
    bundle_t b;
    b            = bundle_t'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
    b.valid      = ($urandom_range(0, 3) != 0);
    b.result_src = 2'($urandom_range(0, 2));
    b.rs1        = 5'($urandom_range(0, 3));
    b.rs2        = 5'($urandom_range(0, 3));
    b.rd         = 5'($urandom_range(0, 3));
    return b;
  endfunction

  function automatic int sat_inc(input int v);
    return (v >= SAT) ? SAT : v + 1;
  endfunction

  // One clock: check the combinational controls mid-cycle against the model,
  // advance the model at the edge, then check the registered state.
  task automatic step(input string tag);
    logic    is_load_use, e_stall, e_flush;
    bundle_t nx;
    @(negedge clk);
    is_load_use = m_ex.valid && m_ex.result_src == 2'b01 && m_ex.rd != 5'd0 &&
                  id.valid && (m_ex.rd == id.rs1 || m_ex.rd == id.rs2);
    if (ext_stall) begin
      e_stall = 1'b1; e_flush = 1'b0; nx = m_ex;
    end else if (pc_src_e) begin
      e_stall = 1'b0; e_flush = 1'b1; nx = '0;
    end else if (is_load_use) begin
      e_stall = 1'b1; e_flush = 1'b0; nx = '0;
    end else begin
      e_stall = 1'b0; e_flush = 1'b0; nx = id;
    end
    check({tag, ".stall_f"}, 256'(stall_f), 256'(e_stall));
    check({tag, ".stall_d"}, 256'(stall_d), 256'(e_stall));
    check({tag, ".flush_d"}, 256'(flush_d), 256'(e_flush));
    @(posedge clk);
    #1;
    m_ex = nx;
    if (cnt_clr) begin
      m_scnt = 0;
      m_fcnt = 0;
    end else begin
      if (e_stall) m_scnt = sat_inc(m_scnt);
      if (e_flush) m_fcnt = sat_inc(m_fcnt);
    end
    check({tag, ".ex"}, 256'(ex_obs), 256'(m_ex));
    check({tag, ".stall_cnt"}, 256'(stall_cnt), 256'(m_scnt));
    check({tag, ".flush_cnt"}, 256'(flush_cnt), 256'(m_fcnt));
  endtask

  initial begin
    bundle_t ld, dep;
    rst_n = 1'b0; ext_stall = 1'b0; pc_src_e = 1'b0; cnt_clr = 1'b0;
    id = rand_instr();
    m_ex = '0; m_scnt = 0; m_fcnt = 0;

    // Reset state.
    #2;
    check("reset.ex", 256'(ex_obs), 256'(0));
    check("reset.cnt", 256'({stall_cnt, flush_cnt}), 256'(0));
    check("reset.ctl", 256'({stall_f, stall_d, flush_d}), 256'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Pass-through: addi x5,x0,7.
    id = mk_instr(1'b1, 2'b00, 1'b1, 0, 0, 5, 7);
    step("addi");
    check("addi.rd", 256'(ex_rd), 256'(5));
    check("addi.imm", 256'(ex_imm_ext), 256'(7));
    check("addi.valid", 256'(ex_valid), 256'(1));

    // Load-use: lw x6,0(x1) then add x7,x6,x2 -> one bubble.
    ld  = mk_instr(1'b1, 2'b01, 1'b1, 1, 0, 6, 0);
    dep = mk_instr(1'b1, 2'b00, 1'b0, 6, 2, 7, 0);
    id = ld;  step("lu.load");
    id = dep; step("lu.stall");
    check("lu.bubble_valid", 256'(ex_valid), 256'(0));
    check("lu.stall_cnt", 256'(stall_cnt), 256'(1));
    step("lu.advance");
    check("lu.dep_rd", 256'(ex_rd), 256'(7));

    // Load to x0 followed by a reader of x0: no stall.
    id = mk_instr(1'b1, 2'b01, 1'b1, 1, 0, 0, 0); step("x0.load");
    id = mk_instr(1'b1, 2'b00, 1'b1, 0, 0, 8, 3); step("x0.use");
    check("x0.stall_cnt", 256'(stall_cnt), 256'(1));

    // Redirect while a load-use hazard is present.
    id = ld; step("redir.load");
    id = dep; pc_src_e = 1'b1;
    step("redir.flush");
    pc_src_e = 1'b0;
    check("redir.flush_cnt", 256'(flush_cnt), 256'(1));
    check("redir.stall_cnt", 256'(stall_cnt), 256'(1));

    // ext_stall for 3 cycles with a pending redirect, then release.
    id = mk_instr(1'b1, 2'b00, 1'b1, 0, 0, 5, 7); step("ext.fill");
    ext_stall = 1'b1; pc_src_e = 1'b1;
    for (int i = 0; i < 3; i++) begin
      id = rand_instr();
      step("ext.hold");
    end
    check("ext.frozen_rd", 256'(ex_rd), 256'(5));
    check("ext.stall_cnt", 256'(stall_cnt), 256'(4));
    ext_stall = 1'b0;
    step("ext.release");
    pc_src_e = 1'b0;
    check("ext.flush_cnt", 256'(flush_cnt), 256'(2));

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      id        = rand_instr();
      ext_stall = ($urandom_range(0, 4) == 0);
      pc_src_e  = ($urandom_range(0, 6) == 0);
      cnt_clr   = ($urandom_range(0, 19) == 0);
      step("rand");
    end
    ext_stall = 1'b0; pc_src_e = 1'b0; cnt_clr = 1'b0;

    // Saturation: clear, then 20 load-use stalls.
    cnt_clr = 1'b1; id = '0; step("sat.clr");
    cnt_clr = 1'b0;
    for (int i = 0; i < 20; i++) begin
      id = ld;  step("sat.load");
      id = dep; step("sat.stall");
      step("sat.adv");
    end
    check("sat.stall_cnt", 256'(stall_cnt), 256'(SAT));
    id = ld; step("clr.load");
    id = dep; cnt_clr = 1'b1;
    step("clr.stall");
    cnt_clr = 1'b0;
    check("clr.stall_cnt", 256'(stall_cnt), 256'(0));

    // Asynchronous reset mid-cycle, then normal capture after release.
    id = mk_instr(1'b1, 2'b00, 1'b1, 3, 4, 9, 11); step("pre_rst");
    id = rand_instr();
    #2 rst_n = 1'b0;
    #1;
    m_ex = '0; m_scnt = 0; m_fcnt = 0;
    check("arst.ex", 256'(ex_obs), 256'(0));
    check("arst.cnt", 256'({stall_cnt, flush_cnt}), 256'(0));
    check("arst.ctl", 256'({stall_f, stall_d, flush_d}), 256'(0));
    #1 rst_n = 1'b1;
    id = mk_instr(1'b1, 2'b00, 1'b1, 0, 0, 5, 7);
    step("post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage of the 5-stage RISC-V core. It registers the main-decoder control bundle, register-file read data, register indices, PC values and extended immediate for the execute stage. It also detects load-use hazards, inserts bubbles, and generates stall/flush controls for the fetch and decode stages. Saturating performance counters track stall and flush cycles.

## Interface
Parameters:
- XLEN, 32, datapath width
- CNT_W, 16, width of each performance counter

Ports:
- clk  input  1  core clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- ext_stall  input  1  memory wait; freezes front end and this stage
- pc_src_e  input  1  branch taken / jump redirect from EX
- cnt_clr  input  1  synchronous clear of both counters
- id_valid  input  1  decode stage holds a real instruction
- id_reg_w, id_mem_w, id_branch, id_jump, id_alu_src  input  1 each  decoder controls
- id_result_src  input  2  00 ALU, 01 memory (load), 10 PC+4
- id_alu_ctrl  input  3  ALU operation
- id_rd1, id_rd2  input  XLEN  register-file read data
- id_rs1, id_rs2, id_rd  input  5 each  register indices
- id_pc, id_pc_plus4, id_imm_ext  input  XLEN each  PC, PC+4, immediate
- ex_*  output  same widths  registered copies of every id_* input (ex_valid, ex_reg_w, …, ex_imm_ext)
- stall_f  output  1  hold PC
- stall_d  output  1  hold IF/ID register
- flush_d  output  1  clear IF/ID register
- stall_cnt  output  CNT_W  load-use and ext stall cycles
- flush_cnt  output  CNT_W  redirect flush events

## Operation
- Load-use hazard: lu = ex_valid & (ex_result_src==2'b01) & (ex_rd!=0) & id_valid & ((ex_rd==id_rs1) | (ex_rd==id_rs2)).
- Bubble: the stage loads ex_valid=0 and all ex_* control bits to 0 (reg_w, mem_w, branch, jump, alu_src, result_src, alu_ctrl). Data, index and PC fields load 0.
- Priority per cycle, highest first:
  - ext_stall=1:
    - The stage holds all ex_* registers.
    - stall_f=stall_d=1, flush_d=0.
    - pc_src_e and lu are ignored this cycle.
    - stall_cnt increments.
  - pc_src_e=1:
    - flush_d=1 and the next ex_* state is a bubble; the ID instruction is killed.
    - stall_f=stall_d=0, even when lu=1.
    - flush_cnt increments.
  - lu=1:
    - stall_f=stall_d=1 and the next ex_* state is a bubble.
    - stall_cnt increments.
  - Otherwise: the stage captures all id_* inputs, with ex_valid=id_valid.
- Counters:
  - Saturate at 2^CNT_W−1.
  - cnt_clr overrides increment (counter→0 that cycle).
  - Counters are unaffected by the rest of the datapath.
- rs1/rs2 compare is performed even for instructions not using rs2 (conservative stall accepted).

## Timing
- Reset (rst_n low, asynchronous): all ex_* = 0 (ex_valid=0), stall_cnt = flush_cnt = 0. stall_f, stall_d and flush_d evaluate to 0 because their inputs are reset.
- Reset released mid-operation: the first rising edge after release captures normally. No partial state is retained.
- Latency: 1 cycle from id_* to ex_*.
- stall_f, stall_d and flush_d are combinational from current ex_* registers, id_* inputs, ext_stall and pc_src_e, and are valid in the same cycle.
- A load-use hazard costs exactly one bubble. On the next cycle the load is in MEM, ex_result_src≠01 for the bubble, so lu=0 and the dependent instruction advances.
- Back-to-back loads with a dependency chain produce one bubble per dependent pair.
- Counter update is visible one cycle after the qualifying cycle.

## Test plan
- Reset: drive rst_n=0 asynchronously mid-cycle with random id_* -> all ex_* and counters read 0 immediately. stall_f = stall_d = flush_d = 0.
- Pass-through: `addi x5,x0,7` decoded (id_reg_w=1, id_alu_src=1, id_rd=5, id_imm_ext=7) -> next cycle ex_rd=5, ex_imm_ext=7, ex_valid=1, no stall.
- Load-use: `lw x6,0(x1)` then `add x7,x6,x2` -> one cycle stall_f = stall_d = 1, ex_valid=0 bubble, stall_cnt=1. The add reaches EX one cycle later. A load with ex_rd=0 and id_rs1=0 -> no stall.
- Redirect: pc_src_e=1 while lu=1 -> flush_d=1, stall_f=0, bubble captured, flush_cnt=1, stall_cnt unchanged.
- ext_stall: hold 3 cycles with pc_src_e=1 -> ex_* frozen, flush_d=0, stall_cnt=3. The flush occurs in the first cycle after release.
- Saturation/clear: CNT_W=4, 20 load-use stalls -> stall_cnt=15. cnt_clr pulse together with a stall -> 0.
